pkt_pass_filter: RTL and testbench
==================================

Name: pkt_pass_filter

Overview:
- Parametrised successor of the single-channel packet pass/discard stage.
- Buffers input packet words and per-packet valid flags in two internal FIFOs. Each packet is forwarded or dropped according to its valid flag and a run-time mode.
- Adds output-space gating, empty-FIFO stalls, oversize-packet truncation and statistics counters.
- Sits between an upstream packet producer (word FIFO plus valid FIFO write interface) and a downstream stage that exposes its packet FIFO fill level.

Parameters:
DATA_W, 139, packet word width; bits [DATA_W-1:DATA_W-3] are the flag field
PKT_DEPTH, 256, internal packet-word FIFO depth (power of 2)
VLD_DEPTH, 64, internal valid-flag FIFO depth (power of 2)
OUT_USEDW_W, 8, width of downstream usedw input
OUT_THRESH, 161, a new packet starts only if out_pkt_usedw < OUT_THRESH
MAX_PKT_WORDS, 94, largest legal packet length in words; must be >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
mode  in  2  00 honour valid flag, 01 forward all, 10 discard all, 11 same as 00
in_pkt_wrreq  in  1  write strobe, packet word FIFO
in_pkt  in  DATA_W  packet word
in_pkt_usedw  out  clog2(PKT_DEPTH)  packet word FIFO fill level
in_valid_wrreq  in  1  write strobe, valid FIFO; one write per packet, at or after the tail word write
in_valid  in  1  per-packet keep(1)/drop(0) flag
out_pkt_wrreq  out  1  output word strobe
out_pkt  out  DATA_W  output word
out_pkt_usedw  in  OUT_USEDW_W  downstream FIFO fill level
out_valid_wrreq  out  1  output valid strobe, one per forwarded packet
out_valid  out  1  output valid flag
fwd_cnt  out  32  forwarded packets, wraps
drop_cnt  out  32  discarded packets, wraps
trunc_cnt  out  16  oversize packets truncated, saturates at 16'hFFFF

Behaviour:
- Reset: synchronous, active-low, sampled on posedge clk. While reset=0:
  - out_pkt_wrreq=0, out_valid_wrreq=0, out_valid=0, out_pkt=0.
  - All counters cleared; state=IDLE.
  - Both FIFOs cleared synchronously; in_pkt_usedw reads 0 on the cycle after reset is sampled low.
  - Writes presented while reset=0 are ignored.
- Reset mid-packet: the partial output packet is abandoned with no out_valid_wrreq. The downstream stage sees a headless fragment and must cope with it.
- Flags: 3'b101 head, 3'b100 middle, 3'b110 tail. Only tail is acted on.
- FIFOs are show-ahead: q shows the head entry; rdreq pops it. Both rdreqs are combinational: rdreq = (pop condition) & !empty.
- Overflow: a write to a full FIFO is dropped. Preventing it is the upstream's job, using in_pkt_usedw.
- Underflow: a read on empty is suppressed by the rdreq gating.
- State machine IDLE / TRANSMIT / DISCARD:
  - IDLE:
    - Outputs strobes 0.
    - When valid FIFO is non-empty and out_pkt_usedw < OUT_THRESH: pop the valid FIFO and sample mode.
    - keep = (mode==01) | (mode!=10 & in_valid_q).
    - keep=1 goes to TRANSMIT; keep=0 goes to DISCARD. The word counter is cleared.
    - Otherwise stay in IDLE. mode changes take effect only here.
  - TRANSMIT:
    - Each cycle the packet FIFO is non-empty: pop, register out_pkt<=q, out_pkt_wrreq<=1, word counter +1.
    - When empty: out_pkt_wrreq<=0 and hold state (stall, no bubble word).
    - Tail popped: out_valid_wrreq<=1 and out_valid<=1 in the same cycle as the tail write; fwd_cnt+1; go to IDLE.
    - Oversize (non-tail word popped at count MAX_PKT_WORDS-1):
      - Write the word with its flag field forced to 3'b110.
      - out_valid_wrreq<=1, out_valid<=0; trunc_cnt+1; go to DISCARD in drain-only mode.
      - fwd_cnt and drop_cnt are unchanged.
  - DISCARD:
    - Pop every available word; no output.
    - On tail popped: go to IDLE. drop_cnt+1 unless entered by truncation.
- Latency: valid flag visible at cycle T with space available → state change at T+1, first pop at T+1, out_pkt_wrreq high at T+2. Throughput is then one word per cycle while input is available.
- Minimum inter-packet gap on output: 1 idle cycle (the IDLE decision cycle).
- out_pkt_usedw is checked only at packet start. OUT_THRESH plus MAX_PKT_WORDS guarantees room for the whole packet.

Decomposition:
- Package pkt_pass_pkg:
  - FLAG_HEAD / FLAG_MID / FLAG_TAIL constants.
  - MODE_HONOUR / MODE_FWD_ALL / MODE_DROP_ALL constants.
  - State encoding typedef (IDLE=0, TRANSMIT=1, DISCARD=2).
- One sub-module: pkt_sync_fifo.
  - Parameters WIDTH and DEPTH; show-ahead; synchronous clear; outputs q, empty, full, usedw.
  - Instantiated twice: DATA_W x PKT_DEPTH for words, 1 x VLD_DEPTH for valid flags.

Test Plan:
- 3-word packet, in_valid=1, mode=00, out_pkt_usedw=0 → 3 output words on consecutive cycles, first at T+2, out_valid_wrreq=1/out_valid=1 with the tail word, fwd_cnt=1.
- 4-word packet with in_valid=0, then 2-word packet with in_valid=1 → only the 2-word packet appears, drop_cnt=1, fwd_cnt=1.
- out_pkt_usedw=161 with a valid packet queued → no pops; drop to 160 → transmission starts 2 cycles later.
- mode=10 with in_valid=1 → dropped, drop_cnt=1. mode=01 with in_valid=0 → forwarded with out_valid=1.
- 100-word packet without tail inside MAX=94 → 94 words out, the 94th with flags 3'b110 and out_valid=0, remaining 6 drained, trunc_cnt=1, fwd_cnt=0, drop_cnt=0.
- Packet words written with 1-cycle gaps mid-packet, and reset=0 asserted mid-TRANSMIT → no bubble or duplicate words; after reset all outputs are 0, in_pkt_usedw=0, counters=0.

Source files
------------

// File: rtl/pkt_pass_pkg.sv
// Shared constants and state encoding for the packet pass/discard filter.
package pkt_pass_pkg;

  localparam logic [2:0] FLAG_HEAD = 3'b101;
  localparam logic [2:0] FLAG_MID  = 3'b100;
  localparam logic [2:0] FLAG_TAIL = 3'b110;

  localparam logic [1:0] MODE_HONOUR   = 2'b00;
  localparam logic [1:0] MODE_FWD_ALL  = 2'b01;
  localparam logic [1:0] MODE_DROP_ALL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSMIT = 2'd1,
    ST_DISCARD  = 2'd2
  } state_e;

  // Mode 11 falls through to honouring the per-packet flag.
  function automatic logic pkt_keep(input logic [1:0] mode, input logic vld);
    return (mode == MODE_FWD_ALL) | ((mode != MODE_DROP_ALL) & vld);
  endfunction

endpackage

// File: rtl/pkt_pass_filter_if.sv
// Word + per-packet-flag FIFO write bus with back-pressure fill level.
interface pkt_pass_filter_if #(
  parameter int DATA_W  = 139,
  parameter int USEDW_W = 8
);
  logic               pkt_wrreq;
  logic [DATA_W-1:0]  pkt;
  logic [USEDW_W-1:0] pkt_usedw;
  logic               valid_wrreq;
  logic               valid;

  modport master (output pkt_wrreq, pkt, valid_wrreq, valid, input  pkt_usedw);
  modport slave  (input  pkt_wrreq, pkt, valid_wrreq, valid, output pkt_usedw);
endinterface

// File: rtl/pkt_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; writes when full are dropped.
module pkt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             wrreq_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdreq_i,
  output logic [WIDTH-1:0] q_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW-1:0]    usedw_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[AW];
  // Fill level is modulo DEPTH: a completely full FIFO reads 0, full_o disambiguates.
  assign usedw_o = cnt_q[AW-1:0];
  assign q_o     = mem[rd_ptr_q];

  assign do_wr = wrreq_i & ~full_o & rst_ni;
  assign do_rd = rdreq_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pkt_pass_filter.sv
// Buffers packets and their keep flags, then forwards or drains each packet
// by flag and mode, truncating oversize packets and keeping statistics.
module pkt_pass_filter
  import pkt_pass_pkg::*;
#(
  parameter int DATA_W        = 139,
  parameter int PKT_DEPTH     = 256,
  parameter int VLD_DEPTH     = 64,
  parameter int OUT_USEDW_W   = 8,
  parameter int OUT_THRESH    = 161,
  parameter int MAX_PKT_WORDS = 94
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  pkt_pass_filter_if.slave    in_if,
  pkt_pass_filter_if.master   out_if,
  output logic [31:0]         fwd_cnt,
  output logic [31:0]         drop_cnt,
  output logic [15:0]         trunc_cnt
);

  localparam int PW = $clog2(PKT_DEPTH);
  localparam int VW = $clog2(VLD_DEPTH);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_WORDS - 1);

  logic [DATA_W-1:0] pkt_q;
  logic              pkt_empty, pkt_full, pkt_rd;
  logic [PW-1:0]     pkt_usedw;
  logic [0:0]        vld_q;
  logic              vld_empty, vld_full, vld_rd;
  logic [VW-1:0]     vld_usedw;

  pkt_sync_fifo #(.WIDTH(DATA_W), .DEPTH(PKT_DEPTH)) u_pkt_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .wrreq_i (in_if.pkt_wrreq),
    .data_i  (in_if.pkt),
    .rdreq_i (pkt_rd),
    .q_o     (pkt_q),
    .empty_o (pkt_empty),
    .full_o  (pkt_full),
    .usedw_o (pkt_usedw)
  );

  pkt_sync_fifo #(.WIDTH(1), .DEPTH(VLD_DEPTH)) u_vld_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .wrreq_i (in_if.valid_wrreq),
    .data_i  (in_if.valid),
    .rdreq_i (vld_rd),
    .q_o     (vld_q),
    .empty_o (vld_empty),
    .full_o  (vld_full),
    .usedw_o (vld_usedw)
  );

  logic unused_fifo_status;
  assign unused_fifo_status = ^{pkt_full, vld_full, vld_usedw};

  assign in_if.pkt_usedw = pkt_usedw;

  state_e            state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              trunc_mode_q, trunc_mode_d;
  logic              opkt_wr_q, opkt_wr_d;
  logic [DATA_W-1:0] opkt_q, opkt_d;
  logic              ovld_wr_q, ovld_wr_d;
  logic              ovld_q, ovld_d;
  logic [31:0]       fwd_q, fwd_d, drop_q, drop_d;
  logic [15:0]       trunc_q, trunc_d;
  logic              is_tail, out_room;

  assign is_tail  = (pkt_q[DATA_W-1 -: 3] == FLAG_TAIL);
  assign out_room = (int'(out_if.pkt_usedw) < OUT_THRESH);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    trunc_mode_d = trunc_mode_q;
    opkt_wr_d    = 1'b0;
    opkt_d       = opkt_q;
    ovld_wr_d    = 1'b0;
    ovld_d       = 1'b0;
    fwd_d        = fwd_q;
    drop_d       = drop_q;
    trunc_d      = trunc_q;
    pkt_rd       = 1'b0;
    vld_rd       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!vld_empty && out_room) begin
          vld_rd       = 1'b1;
          wcnt_d       = '0;
          trunc_mode_d = 1'b0;
          state_d      = pkt_keep(mode, vld_q[0]) ? ST_TRANSMIT : ST_DISCARD;
        end
      end
      ST_TRANSMIT: begin
        if (!pkt_empty) begin
          pkt_rd    = 1'b1;
          opkt_wr_d = 1'b1;
          opkt_d    = pkt_q;
          wcnt_d    = wcnt_q + 1'b1;
          if (is_tail) begin
            ovld_wr_d = 1'b1;
            ovld_d    = 1'b1;
            fwd_d     = fwd_q + 32'd1;
            state_d   = ST_IDLE;
          end else if (wcnt_q == LAST_IDX) begin
            // Close the output packet here with a forced tail flagged invalid,
            // then silently drain the rest of the input packet.
            opkt_d[DATA_W-1 -: 3] = FLAG_TAIL;
            ovld_wr_d    = 1'b1;
            trunc_d      = (trunc_q == 16'hFFFF) ? trunc_q : trunc_q + 16'd1;
            trunc_mode_d = 1'b1;
            state_d      = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (!pkt_empty) begin
          pkt_rd = 1'b1;
          if (is_tail) begin
            if (!trunc_mode_q) drop_d = drop_q + 32'd1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      trunc_mode_q <= 1'b0;
      opkt_wr_q    <= 1'b0;
      opkt_q       <= '0;
      ovld_wr_q    <= 1'b0;
      ovld_q       <= 1'b0;
      fwd_q        <= '0;
      drop_q       <= '0;
      trunc_q      <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      trunc_mode_q <= trunc_mode_d;
      opkt_wr_q    <= opkt_wr_d;
      opkt_q       <= opkt_d;
      ovld_wr_q    <= ovld_wr_d;
      ovld_q       <= ovld_d;
      fwd_q        <= fwd_d;
      drop_q       <= drop_d;
      trunc_q      <= trunc_d;
    end
  end

  assign out_if.pkt_wrreq   = opkt_wr_q;
  assign out_if.pkt         = opkt_q;
  assign out_if.valid_wrreq = ovld_wr_q;
  assign out_if.valid       = ovld_q;
  assign fwd_cnt            = fwd_q;
  assign drop_cnt           = drop_q;
  assign trunc_cnt          = trunc_q;

endmodule

// File: tb/tb_pkt_pass_filter.sv
// Directed + randomized bench for pkt_pass_filter against a packet-level reference model.
module tb_pkt_pass_filter;
  import pkt_pass_pkg::*;

  localparam int DATA_W = 139;
  localparam int MAXW   = 94;
  typedef logic [DATA_W-1:0] word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] fwd_cnt, drop_cnt;
  logic [15:0] trunc_cnt;

  pkt_pass_filter_if #(.DATA_W(DATA_W), .USEDW_W(8)) in_if ();
  pkt_pass_filter_if #(.DATA_W(DATA_W), .USEDW_W(8)) out_if ();

  pkt_pass_filter #(
    .DATA_W(DATA_W), .PKT_DEPTH(256), .VLD_DEPTH(64), .OUT_USEDW_W(8),
    .OUT_THRESH(161), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_if     (in_if),
    .out_if    (out_if),
    .fwd_cnt   (fwd_cnt),
    .drop_cnt  (drop_cnt),
    .trunc_cnt (trunc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t got_w[$], exp_w[$];
  int    got_c[$], got_v[$], exp_v[$];
  int    e_fwd = 0, e_drop = 0, e_trunc = 0;
  int    n_assert = 0, n_fail = 0;
  int    vld_cyc = 0;

  // Valid strobes are logged as (words seen so far << 1) | valid so that
  // their alignment with the closing word is checked too.
  always @(negedge clk) begin
    if (out_if.pkt_wrreq) begin
      got_w.push_back(out_if.pkt);
      got_c.push_back(cyc);
    end
    if (out_if.valid_wrreq) got_v.push_back((got_w.size() << 1) | int'(out_if.valid));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mkword(input logic [2:0] f);
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return {f, r[DATA_W-4:0]};
  endfunction

  // Reference: a kept packet goes out whole, or as its first MAXW words with
  // the last re-flagged as tail and marked invalid; a dropped one leaves nothing.
  task automatic model(input word_t pk[$], input bit v);
    word_t w;
    bit keep;
    keep = (mode == MODE_FWD_ALL) || (mode != MODE_DROP_ALL && v);
    if (!keep) e_drop++;
    else if (pk.size() <= MAXW) begin
      foreach (pk[i]) exp_w.push_back(pk[i]);
      exp_v.push_back((exp_w.size() << 1) | 1);
      e_fwd++;
    end else begin
      for (int i = 0; i < MAXW - 1; i++) exp_w.push_back(pk[i]);
      w = pk[MAXW-1];
      w[DATA_W-1 -: 3] = FLAG_TAIL;
      exp_w.push_back(w);
      exp_v.push_back(exp_w.size() << 1);
      e_trunc++;
    end
  endtask

  task automatic send_pkt(input int len, input bit v, input int gap_pct);
    word_t pk[$];
    word_t w;
    for (int i = 0; i < len; i++) begin
      w = mkword(i == len-1 ? FLAG_TAIL : (i == 0 ? FLAG_HEAD : FLAG_MID));
      pk.push_back(w);
      in_if.pkt_wrreq = 1'b1;
      in_if.pkt = w;
      tick();
      in_if.pkt_wrreq = 1'b0;
      if (int'($urandom_range(99)) < gap_pct) tick();
    end
    in_if.valid_wrreq = 1'b1;
    in_if.valid = v;
    tick();
    in_if.valid_wrreq = 1'b0;
    vld_cyc = cyc;
    model(pk, v);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (in_if.pkt_usedw != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, " drain_in_time"}, 160'(n < 3000), 160'(1));
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, " word_count"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s word[%0d]", tag, i), got_w[i], exp_w[i]);
    chk({tag, " valid_count"}, got_v.size(), exp_v.size());
    n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s valid[%0d]", tag, i), got_v[i], exp_v[i]);
    chk({tag, " fwd_cnt"},   fwd_cnt,   e_fwd);
    chk({tag, " drop_cnt"},  drop_cnt,  e_drop);
    chk({tag, " trunc_cnt"}, trunc_cnt, e_trunc);
    got_w.delete(); got_c.delete(); got_v.delete();
    exp_w.delete(); exp_v.delete();
  endtask

  task automatic chk_contig(input string tag, input int n);
    for (int i = 1; i < n && i < got_c.size(); i++)
      chk($sformatf("%s contiguous[%0d]", tag, i), got_c[i] - got_c[0], i);
  endtask

  initial begin
    int t0, n;
    in_if.pkt_wrreq = 1'b0; in_if.pkt = '0;
    in_if.valid_wrreq = 1'b0; in_if.valid = 1'b0;
    out_if.pkt_usedw = '0;
    repeat (3) tick();
    // A write while reset is low must be ignored.
    in_if.pkt_wrreq = 1'b1; in_if.pkt = mkword(FLAG_TAIL);
    tick();
    in_if.pkt_wrreq = 1'b0;
    chk("reset out_pkt_wrreq",   out_if.pkt_wrreq,   0);
    chk("reset out_valid_wrreq", out_if.valid_wrreq, 0);
    chk("reset out_valid",       out_if.valid,       0);
    chk("reset out_pkt",         out_if.pkt,         0);
    chk("reset in_pkt_usedw",    in_if.pkt_usedw,    0);
    chk("reset fwd_cnt",  fwd_cnt,  0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset trunc_cnt", trunc_cnt, 0);
    reset = 1'b1;
    tick();
    chk("post-reset usedw", in_if.pkt_usedw, 0);

    // 3-word forwarded packet: first word two cycles after the flag is visible
    mode = MODE_HONOUR;
    send_pkt(3, 1'b1, 0);
    t0 = vld_cyc;
    drain("t1");
    chk("t1 first word latency", got_c.size() > 0 ? got_c[0] - t0 : -1, 2);
    chk_contig("t1", 3);
    check_stream("t1");

    // dropped packet then a kept one
    send_pkt(4, 1'b0, 0);
    send_pkt(2, 1'b1, 0);
    drain("t2");
    check_stream("t2");

    // downstream fill-level gate, boundary 161 vs 160
    out_if.pkt_usedw = 8'd161;
    send_pkt(2, 1'b1, 0);
    repeat (10) tick();
    chk("gate held usedw", in_if.pkt_usedw, 2);
    chk("gate held no output", got_w.size(), 0);
    out_if.pkt_usedw = 8'd160;
    t0 = cyc;
    n = 0;
    while (got_w.size() == 0 && n < 20) begin tick(); n++; end
    chk("gate release latency", got_c.size() > 0 ? got_c[0] - t0 : -1, 2);
    drain("t3");
    check_stream("t3");
    out_if.pkt_usedw = '0;

    // mode overrides
    mode = MODE_DROP_ALL; send_pkt(3, 1'b1, 0); drain("t4a");
    mode = MODE_FWD_ALL;  send_pkt(3, 1'b0, 0); drain("t4b");
    mode = 2'b11;         send_pkt(2, 1'b0, 0); send_pkt(2, 1'b1, 0); drain("t4c");
    check_stream("t4");

    // oversize truncation and its boundaries
    mode = MODE_HONOUR;
    send_pkt(100, 1'b1, 0); drain("t5a"); check_stream("t5a");
    send_pkt(MAXW, 1'b1, 0); drain("t5b"); check_stream("t5b");
    send_pkt(MAXW + 1, 1'b1, 0); send_pkt(3, 1'b1, 0); drain("t5c"); check_stream("t5c");

    // gappy input must still come out as one contiguous burst
    send_pkt(6, 1'b1, 100);
    drain("t6");
    chk_contig("t6", 6);
    check_stream("t6");

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      mode = 2'($urandom_range(3));
      out_if.pkt_usedw = 8'($urandom_range(160));
      for (int p = 0; p < 3; p++)
        send_pkt(int'($urandom_range(12, 1)), 1'($urandom_range(1)), 30);
      drain($sformatf("rnd%0d", r));
      check_stream($sformatf("rnd%0d", r));
    end
    out_if.pkt_usedw = '0;

    // reset in the middle of a transmission
    mode = MODE_HONOUR;
    send_pkt(40, 1'b1, 0);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("midrst out_pkt_wrreq",   out_if.pkt_wrreq,   0);
    chk("midrst out_valid_wrreq", out_if.valid_wrreq, 0);
    chk("midrst out_valid",       out_if.valid,       0);
    chk("midrst out_pkt",         out_if.pkt,         0);
    chk("midrst in_pkt_usedw",    in_if.pkt_usedw,    0);
    chk("midrst fwd_cnt",   fwd_cnt,   0);
    chk("midrst drop_cnt",  drop_cnt,  0);
    chk("midrst trunc_cnt", trunc_cnt, 0);
    reset = 1'b1;
    tick();
    got_w.delete(); got_c.delete(); got_v.delete();
    exp_w.delete(); exp_v.delete();
    e_fwd = 0; e_drop = 0; e_trunc = 0;
    send_pkt(2, 1'b1, 0);
    drain("t7");
    check_stream("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
